// File: rtl/crt_loader_if.sv
// CRT loader bus: download byte stream in, bank descriptors and SDRAM payload writes out.
interface crt_loader_if;
  logic        crt_download;
  logic        ioctl_wr;
  logic [7:0]  ioctl_data;
  logic        cart_loading;
  logic        cart_attached;
  logic        crt_error;
  logic [15:0] cart_id;
  logic [7:0]  cart_exrom;
  logic [7:0]  cart_game;
  logic [15:0] cart_bank_laddr;
  logic [15:0] cart_bank_size;
  logic [15:0] cart_bank_num;
  logic [7:0]  cart_bank_type;
  logic [23:0] cart_bank_raddr;
  logic        cart_bank_wr;
  logic [23:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_wr;

  modport master (
    input  crt_download, ioctl_wr, ioctl_data,
    output cart_loading, cart_attached, crt_error, cart_id, cart_exrom, cart_game,
           cart_bank_laddr, cart_bank_size, cart_bank_num, cart_bank_type,
           cart_bank_raddr, cart_bank_wr, mem_addr, mem_data, mem_wr
  );

  modport slave (
    output crt_download, ioctl_wr, ioctl_data,
    input  cart_loading, cart_attached, crt_error, cart_id, cart_exrom, cart_game,
           cart_bank_laddr, cart_bank_size, cart_bank_num, cart_bank_type,
           cart_bank_raddr, cart_bank_wr, mem_addr, mem_data, mem_wr
  );
endinterface

// File: rtl/crt_loader.sv
// Streaming .CRT parser: validates file/CHIP headers, relocates payloads into 8K-aligned
// SDRAM slots and emits one bank descriptor per CHIP packet.
module crt_loader #(
  parameter logic [23:0] ROM_BASE   = 24'h100000,
  parameter int          ALLOC_BITS = 20
) (
  input  logic         clk32,
  input  logic         reset,
  crt_loader_if.master bus
);
  typedef enum logic [2:0] {IDLE, FHDR, FSKIP, CHDR, DATA, PSKIP, DONE, ERR} state_t;

  localparam int            AW        = ALLOC_BITS + 1;
  localparam logic [127:0]  FILE_SIG  = "C64 CARTRIDGE   ";
  localparam logic [31:0]   CHIP_SIG  = "CHIP";
  localparam logic [AW:0]   WIN_LIMIT = (AW+1)'(1) << ALLOC_BITS;

  function automatic logic [AW-1:0] round_up_8k(input logic [15:0] size);
    logic [16:0] padded;
    padded        = {1'b0, size} + 17'h1FFF;
    padded[12:0]  = '0;
    return AW'(padded);
  endfunction

  state_t        state_q, state_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [31:0]   hdr_len_q, hdr_len_d;
  logic [31:0]   pkt_len_q, pkt_len_d;
  logic [15:0]   size_q, size_d;
  logic [7:0]    ch_type_q, ch_type_d;
  logic [15:0]   ch_bank_q, ch_bank_d;
  logic [15:0]   ch_laddr_q, ch_laddr_d;
  logic [AW-1:0] alloc_q, alloc_d;
  logic          chip_seen_q, chip_seen_d;
  logic          dl_prev_q, loading_q;
  logic          attached_q, attached_d;
  logic          error_q, error_d;
  logic [15:0]   id_q, id_d;
  logic [7:0]    exrom_q, exrom_d;
  logic [7:0]    game_q, game_d;
  logic [15:0]   bladdr_q, bladdr_d;
  logic [15:0]   bsize_q, bsize_d;
  logic [15:0]   bnum_q, bnum_d;
  logic [7:0]    btype_q, btype_d;
  logic [23:0]   braddr_q, braddr_d;
  logic          bwr_q, bwr_d;
  logic [23:0]   mem_addr_p1, mem_addr_d;
  logic [7:0]    mem_data_p1, mem_data_d;
  logic          vld_p1, vld_d;

  logic          vld_p0;
  logic [7:0]    data_p0;
  logic          rise, fall, to_err;
  logic [15:0]   size_fin;
  logic [AW:0]   end_pos;

  assign vld_p0  = bus.ioctl_wr;
  assign data_p0 = bus.ioctl_data;
  // dl_prev resets high so a download already in progress at reset release is not seen as a start
  assign rise    = bus.crt_download & ~dl_prev_q;
  assign fall    = ~bus.crt_download & dl_prev_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hdr_len_d   = hdr_len_q;
    pkt_len_d   = pkt_len_q;
    size_d      = size_q;
    ch_type_d   = ch_type_q;
    ch_bank_d   = ch_bank_q;
    ch_laddr_d  = ch_laddr_q;
    alloc_d     = alloc_q;
    chip_seen_d = chip_seen_q;
    attached_d  = attached_q;
    error_d     = error_q;
    id_d        = id_q;
    exrom_d     = exrom_q;
    game_d      = game_q;
    bladdr_d    = bladdr_q;
    bsize_d     = bsize_q;
    bnum_d      = bnum_q;
    btype_d     = btype_q;
    braddr_d    = braddr_q;
    bwr_d       = 1'b0;
    mem_addr_d  = mem_addr_p1;
    mem_data_d  = mem_data_p1;
    vld_d       = 1'b0;
    to_err      = 1'b0;
    size_fin    = {size_q[7:0], data_p0};
    end_pos     = {1'b0, alloc_q} + (AW+1)'(size_fin);

    if (rise) begin
      state_d     = FHDR;
      cnt_d       = '0;
      hdr_len_d   = '0;
      alloc_d     = '0;
      chip_seen_d = 1'b0;
      attached_d  = 1'b0;
      error_d     = 1'b0;
    end else begin
      if (vld_p0) begin
        case (state_q)
          FHDR: begin
            cnt_d = cnt_q + 32'd1;
            if (cnt_q < 32'd16 && data_p0 != 8'(FILE_SIG >> {~cnt_q[3:0], 3'b000}))
              to_err = 1'b1;
            case (cnt_q)
              32'h10, 32'h11, 32'h12, 32'h13: hdr_len_d = {hdr_len_q[23:0], data_p0};
              32'h16: id_d[15:8] = data_p0;
              32'h17: id_d[7:0]  = data_p0;
              32'h18: exrom_d    = data_p0;
              32'h19: game_d     = data_p0;
              32'h3F: begin
                if (hdr_len_q > 32'h40) begin
                  state_d = FSKIP;
                end else begin
                  state_d = CHDR;
                  cnt_d   = '0;
                end
              end
              default: ;
            endcase
          end
          FSKIP: begin
            cnt_d = cnt_q + 32'd1;
            if (cnt_q == hdr_len_q - 32'd1) begin
              state_d = CHDR;
              cnt_d   = '0;
            end
          end
          CHDR: begin
            cnt_d = cnt_q + 32'd1;
            case (cnt_q[3:0])
              4'd0, 4'd1, 4'd2, 4'd3:
                if (data_p0 != 8'(CHIP_SIG >> {~cnt_q[1:0], 3'b000})) to_err = 1'b1;
              4'd4, 4'd5, 4'd6: pkt_len_d = {pkt_len_q[23:0], data_p0};
              4'd7: begin
                pkt_len_d = {pkt_len_q[23:0], data_p0};
                if ({pkt_len_q[23:0], data_p0} < 32'h10) to_err = 1'b1;
              end
              4'd9:         ch_type_d  = data_p0;
              4'd10, 4'd11: ch_bank_d  = {ch_bank_q[7:0], data_p0};
              4'd12, 4'd13: ch_laddr_d = {ch_laddr_q[7:0], data_p0};
              4'd14:        size_d     = {size_q[7:0], data_p0};
              4'd15: begin
                size_d = size_fin;
                // a packet that would not fit the window is rejected before any descriptor or write
                if (size_fin != 16'd0 && end_pos > WIN_LIMIT) begin
                  to_err = 1'b1;
                end else begin
                  chip_seen_d = 1'b1;
                  bwr_d       = 1'b1;
                  bladdr_d    = ch_laddr_q;
                  bsize_d     = size_fin;
                  bnum_d      = ch_bank_q;
                  btype_d     = ch_type_q;
                  braddr_d    = ROM_BASE + 24'(alloc_q);
                  cnt_d       = '0;
                  if (size_fin != 16'd0) begin
                    state_d = DATA;
                  end else if (pkt_len_q > 32'd16) begin
                    state_d = PSKIP;
                    cnt_d   = 32'd16;
                  end else begin
                    state_d = CHDR;
                  end
                end
              end
              default: ;
            endcase
          end
          DATA: begin
            vld_d      = 1'b1;
            mem_data_d = data_p0;
            mem_addr_d = ROM_BASE + 24'(alloc_q) + 24'(cnt_q[15:0]);
            cnt_d      = cnt_q + 32'd1;
            if (cnt_q[15:0] == size_q - 16'd1) begin
              alloc_d = alloc_q + round_up_8k(size_q);
              if (pkt_len_q > 32'(size_q) + 32'd16) begin
                state_d = PSKIP;
                cnt_d   = 32'(size_q) + 32'd16;
              end else begin
                state_d = CHDR;
                cnt_d   = '0;
              end
            end
          end
          PSKIP: begin
            cnt_d = cnt_q + 32'd1;
            if (cnt_q == pkt_len_q - 32'd1) begin
              state_d = CHDR;
              cnt_d   = '0;
            end
          end
          default: ;
        endcase
      end

      if (to_err) state_d = ERR;

      // end-of-download check sees the state after this cycle's byte
      if (fall) begin
        case (state_d)
          FHDR, FSKIP, CHDR, DATA, PSKIP: begin
            if (state_d == CHDR && cnt_d == 32'd0 && chip_seen_d) begin
              state_d    = DONE;
              attached_d = 1'b1;
            end else begin
              state_d = ERR;
            end
          end
          default: ;
        endcase
      end

      if (state_d == ERR) begin
        error_d    = 1'b1;
        attached_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk32 or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hdr_len_q   <= '0;
      pkt_len_q   <= '0;
      size_q      <= '0;
      ch_type_q   <= '0;
      ch_bank_q   <= '0;
      ch_laddr_q  <= '0;
      alloc_q     <= '0;
      chip_seen_q <= 1'b0;
      dl_prev_q   <= 1'b1;
      loading_q   <= 1'b0;
      attached_q  <= 1'b0;
      error_q     <= 1'b0;
      id_q        <= '0;
      exrom_q     <= '0;
      game_q      <= '0;
      bladdr_q    <= '0;
      bsize_q     <= '0;
      bnum_q      <= '0;
      btype_q     <= '0;
      braddr_q    <= '0;
      bwr_q       <= 1'b0;
      mem_addr_p1 <= '0;
      mem_data_p1 <= '0;
      vld_p1      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hdr_len_q   <= hdr_len_d;
      pkt_len_q   <= pkt_len_d;
      size_q      <= size_d;
      ch_type_q   <= ch_type_d;
      ch_bank_q   <= ch_bank_d;
      ch_laddr_q  <= ch_laddr_d;
      alloc_q     <= alloc_d;
      chip_seen_q <= chip_seen_d;
      dl_prev_q   <= bus.crt_download;
      loading_q   <= bus.crt_download;
      attached_q  <= attached_d;
      error_q     <= error_d;
      id_q        <= id_d;
      exrom_q     <= exrom_d;
      game_q      <= game_d;
      bladdr_q    <= bladdr_d;
      bsize_q     <= bsize_d;
      bnum_q      <= bnum_d;
      btype_q     <= btype_d;
      braddr_q    <= braddr_d;
      bwr_q       <= bwr_d;
      mem_addr_p1 <= mem_addr_d;
      mem_data_p1 <= mem_data_d;
      vld_p1      <= vld_d;
    end
  end

  assign bus.cart_loading    = loading_q;
  assign bus.cart_attached   = attached_q;
  assign bus.crt_error       = error_q;
  assign bus.cart_id         = id_q;
  assign bus.cart_exrom      = exrom_q;
  assign bus.cart_game       = game_q;
  assign bus.cart_bank_laddr = bladdr_q;
  assign bus.cart_bank_size  = bsize_q;
  assign bus.cart_bank_num   = bnum_q;
  assign bus.cart_bank_type  = btype_q;
  assign bus.cart_bank_raddr = braddr_q;
  assign bus.cart_bank_wr    = bwr_q;
  assign bus.mem_addr        = mem_addr_p1;
  assign bus.mem_data        = mem_data_p1;
  assign bus.mem_wr          = vld_p1;
endmodule

// File: tb/tb_crt_loader.sv
// Directed bench for crt_loader: valid images, header/packet padding, error cases, reset mid-load.
module tb_crt_loader;
  logic clk32 = 1'b0;
  logic reset = 1'b0;

  crt_loader_if bus ();

  crt_loader #(.ROM_BASE(24'h100000), .ALLOC_BITS(20)) dut (
    .clk32 (clk32),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk32 = ~clk32;

  int          n_pass   = 0;
  int          n_total  = 0;
  int          wr_cnt   = 0;
  int          wr_bad   = 0;
  int          bank_cnt = 0;
  int          pkt_seq  = 0;
  int          seen_seq = 0;
  int          mon_off  = 0;
  logic [23:0] last_addr = '0;
  logic [23:0] pkt_base  = '0;
  logic [127:0] sig;
  int          w0, b0;

  // Payload writes must be contiguous from the packet's expected base, data = offset ^ 0xA5
  always @(negedge clk32) begin
    if (pkt_seq != seen_seq) begin
      seen_seq <= pkt_seq;
      mon_off  <= 0;
    end else if (bus.mem_wr === 1'b1) begin
      if (bus.mem_addr !== pkt_base + 24'(mon_off) || bus.mem_data !== (8'(mon_off) ^ 8'hA5))
        wr_bad <= wr_bad + 1;
      last_addr <= bus.mem_addr;
      wr_cnt    <= wr_cnt + 1;
      mon_off   <= mon_off + 1;
    end
    if (bus.cart_bank_wr === 1'b1) bank_cnt <= bank_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk32);
  endtask

  task automatic send(input logic [7:0] b);
    bus.ioctl_data = b;
    bus.ioctl_wr   = 1'b1;
    @(negedge clk32);
    bus.ioctl_wr   = 1'b0;
  endtask

  task automatic start_dl();
    bus.crt_download = 1'b1;
    tick(2);
  endtask

  task automatic stop_dl();
    bus.crt_download = 1'b0;
    @(negedge clk32);
  endtask

  task automatic new_pkt(input logic [23:0] base);
    tick(1);
    pkt_base = base;
    pkt_seq++;
    tick(1);
  endtask

  task automatic send_fhdr(input logic [31:0] hlen, input logic [15:0] id,
                           input logic [7:0] ex, input logic [7:0] gm, input int bad_idx);
    logic [7:0] b;
    for (int i = 0; i < 64; i++) begin
      b = 8'h00;
      if (i < 16) b = sig[8*(15-i) +: 8];
      case (i)
        16, 17, 18, 19: b = hlen[8*(19-i) +: 8];
        22:      b = id[15:8];
        23:      b = id[7:0];
        24:      b = ex;
        25:      b = gm;
        default: ;
      endcase
      if (i == bad_idx) b = b ^ 8'h01;
      send(b);
    end
  endtask

  task automatic send_chip(input logic [31:0] magic, input logic [31:0] plen,
                           input logic [15:0] typ, input logic [15:0] bank,
                           input logic [15:0] laddr, input logic [15:0] size);
    logic [127:0] h;
    h = {magic, plen, typ, bank, laddr, size};
    for (int i = 0; i < 16; i++) send(h[8*(15-i) +: 8]);
  endtask

  task automatic send_payload(input int start, input int n);
    for (int i = start; i < start + n; i++) send(8'(i) ^ 8'hA5);
  endtask

  task automatic send_pad(input int n);
    for (int i = 0; i < n; i++) send(8'hEE);
  endtask

  initial begin
    sig              = "C64 CARTRIDGE   ";
    bus.crt_download = 1'b0;
    bus.ioctl_wr     = 1'b0;
    bus.ioctl_data   = 8'h00;
    tick(3);
    check("rst_loading",  32'(bus.cart_loading), 32'd0);
    check("rst_attached", 32'(bus.cart_attached), 32'd0);
    check("rst_error",    32'(bus.crt_error), 32'd0);
    check("rst_mem_wr",   32'(bus.mem_wr), 32'd0);
    check("rst_bank_wr",  32'(bus.cart_bank_wr), 32'd0);
    check("rst_raddr",    32'(bus.cart_bank_raddr), 32'd0);
    reset = 1'b1;
    tick(2);

    // Generic 8K cartridge
    w0 = wr_cnt; b0 = bank_cnt;
    start_dl();
    check("t1_loading", 32'(bus.cart_loading), 32'd1);
    send_fhdr(32'h40, 16'h0000, 8'h00, 8'h01, -1);
    new_pkt(24'h100000);
    send_chip("CHIP", 32'h2010, 16'h0000, 16'h0000, 16'h8000, 16'h2000);
    check("t1_bank_wr", 32'(bus.cart_bank_wr), 32'd1);
    check("t1_raddr",   32'(bus.cart_bank_raddr), 32'h100000);
    check("t1_laddr",   32'(bus.cart_bank_laddr), 32'h8000);
    check("t1_size",    32'(bus.cart_bank_size), 32'h2000);
    send(8'hA5);
    check("t1_first_wr",   32'(bus.mem_wr), 32'd1);
    check("t1_first_addr", 32'(bus.mem_addr), 32'h100000);
    check("t1_bank_wr_once", 32'(bus.cart_bank_wr), 32'd0);
    send_payload(1, 16'h1FFF);
    tick(2);
    check("t1_wr_count", 32'(wr_cnt - w0), 32'h2000);
    check("t1_wr_seq",   32'(wr_bad), 32'd0);
    check("t1_last",     32'(last_addr), 32'h101FFF);
    check("t1_bank_cnt", 32'(bank_cnt - b0), 32'd1);
    stop_dl();
    check("t1_attached", 32'(bus.cart_attached), 32'd1);
    check("t1_error",    32'(bus.crt_error), 32'd0);
    check("t1_id",       32'(bus.cart_id), 32'd0);
    check("t1_exrom",    32'(bus.cart_exrom), 32'd0);
    check("t1_game",     32'(bus.cart_game), 32'd1);
    check("t1_loading_off", 32'(bus.cart_loading), 32'd0);
    tick(2);

    // Two CHIPs, 16K then 4K
    w0 = wr_cnt;
    start_dl();
    send_fhdr(32'h40, 16'h0005, 8'h01, 8'h00, -1);
    new_pkt(24'h100000);
    send_chip("CHIP", 32'h4010, 16'h0000, 16'h0000, 16'h8000, 16'h4000);
    check("t2_raddr0", 32'(bus.cart_bank_raddr), 32'h100000);
    send_payload(0, 16'h4000);
    new_pkt(24'h104000);
    send_chip("CHIP", 32'h1010, 16'h0002, 16'h0001, 16'hA000, 16'h1000);
    check("t2_raddr1", 32'(bus.cart_bank_raddr), 32'h104000);
    check("t2_num1",   32'(bus.cart_bank_num), 32'd1);
    check("t2_type1",  32'(bus.cart_bank_type), 32'd2);
    check("t2_laddr1", 32'(bus.cart_bank_laddr), 32'hA000);
    send_payload(0, 16'h1000);
    tick(2);
    check("t2_wr_count", 32'(wr_cnt - w0), 32'h5000);
    check("t2_wr_seq",   32'(wr_bad), 32'd0);
    check("t2_last",     32'(last_addr), 32'h104FFF);
    stop_dl();
    check("t2_attached", 32'(bus.cart_attached), 32'd1);
    check("t2_id",       32'(bus.cart_id), 32'h0005);
    check("t2_exrom",    32'(bus.cart_exrom), 32'd1);
    check("t2_game",     32'(bus.cart_game), 32'd0);
    tick(2);

    // Header length 0x20 is treated as 0x40
    w0 = wr_cnt;
    start_dl();
    send_fhdr(32'h20, 16'h0000, 8'h00, 8'h01, -1);
    new_pkt(24'h100000);
    send_chip("CHIP", 32'h20, 16'h0000, 16'h0000, 16'h8000, 16'h0010);
    check("t3_bank_wr", 32'(bus.cart_bank_wr), 32'd1);
    check("t3_raddr",   32'(bus.cart_bank_raddr), 32'h100000);
    send_payload(0, 16);
    tick(2);
    check("t3_wr_count", 32'(wr_cnt - w0), 32'd16);
    stop_dl();
    check("t3_attached", 32'(bus.cart_attached), 32'd1);
    check("t3_error",    32'(bus.crt_error), 32'd0);
    tick(2);

    // Header pad of 8 bytes and trailing packet pad of 16 bytes
    b0 = bank_cnt;
    start_dl();
    send_fhdr(32'h48, 16'h0000, 8'h00, 8'h01, -1);
    send_pad(8);
    new_pkt(24'h100000);
    send_chip("CHIP", 32'h2020, 16'h0000, 16'h0000, 16'h8000, 16'h2000);
    check("t4_bank_wr0", 32'(bus.cart_bank_wr), 32'd1);
    send_payload(0, 16'h2000);
    send_pad(16);
    new_pkt(24'h102000);
    send_chip("CHIP", 32'h110, 16'h0000, 16'h0001, 16'hA000, 16'h0100);
    check("t4_bank_wr1", 32'(bus.cart_bank_wr), 32'd1);
    check("t4_raddr1",   32'(bus.cart_bank_raddr), 32'h102000);
    send_payload(0, 16'h100);
    tick(2);
    check("t4_bank_cnt", 32'(bank_cnt - b0), 32'd2);
    check("t4_wr_seq",   32'(wr_bad), 32'd0);
    stop_dl();
    check("t4_attached", 32'(bus.cart_attached), 32'd1);
    tick(2);

    // Corrupt signature byte 5
    w0 = wr_cnt; b0 = bank_cnt;
    start_dl();
    check("e1_attached_clr", 32'(bus.cart_attached), 32'd0);
    send_fhdr(32'h40, 16'h0000, 8'h00, 8'h01, 5);
    check("e1_error_early", 32'(bus.crt_error), 32'd1);
    new_pkt(24'h100000);
    send_chip("CHIP", 32'h20, 16'h0000, 16'h0000, 16'h8000, 16'h0010);
    send_payload(0, 16);
    tick(2);
    check("e1_no_wr",   32'(wr_cnt - w0), 32'd0);
    check("e1_no_bank", 32'(bank_cnt - b0), 32'd0);
    stop_dl();
    check("e1_error",    32'(bus.crt_error), 32'd1);
    check("e1_attached", 32'(bus.cart_attached), 32'd0);
    tick(2);

    // CHIP magic "CHIQ"
    b0 = bank_cnt;
    start_dl();
    check("e2_error_clr", 32'(bus.crt_error), 32'd0);
    send_fhdr(32'h40, 16'h0000, 8'h00, 8'h01, -1);
    send_chip("CHIQ", 32'h20, 16'h0000, 16'h0000, 16'h8000, 16'h0010);
    send_payload(0, 16);
    tick(2);
    check("e2_no_bank", 32'(bank_cnt - b0), 32'd0);
    stop_dl();
    check("e2_error",    32'(bus.crt_error), 32'd1);
    check("e2_attached", 32'(bus.cart_attached), 32'd0);
    tick(2);

    // Download dropped 100 bytes into DATA
    w0 = wr_cnt;
    start_dl();
    send_fhdr(32'h40, 16'h0000, 8'h00, 8'h01, -1);
    new_pkt(24'h100000);
    send_chip("CHIP", 32'h2010, 16'h0000, 16'h0000, 16'h8000, 16'h2000);
    send_payload(0, 100);
    stop_dl();
    check("e3_error",    32'(bus.crt_error), 32'd1);
    check("e3_attached", 32'(bus.cart_attached), 32'd0);
    tick(2);
    check("e3_wr_count", 32'(wr_cnt - w0), 32'd100);
    tick(2);

    // Reset mid-DATA, then a fresh valid download
    w0 = wr_cnt;
    start_dl();
    send_fhdr(32'h40, 16'h0000, 8'h00, 8'h01, -1);
    new_pkt(24'h100000);
    send_chip("CHIP", 32'h110, 16'h0000, 16'h0003, 16'h8000, 16'h0100);
    send_payload(0, 50);
    reset = 1'b0;
    #1;
    check("r_mem_wr",  32'(bus.mem_wr), 32'd0);
    check("r_loading", 32'(bus.cart_loading), 32'd0);
    check("r_raddr",   32'(bus.cart_bank_raddr), 32'd0);
    check("r_bsize",   32'(bus.cart_bank_size), 32'd0);
    check("r_game",    32'(bus.cart_game), 32'd0);
    tick(2);
    reset = 1'b1;
    tick(1);
    send_payload(50, 20);
    tick(2);
    check("r_ignored_wr", 32'(wr_cnt - w0), 32'd50);
    stop_dl();
    check("r_error_after",    32'(bus.crt_error), 32'd0);
    check("r_attached_after", 32'(bus.cart_attached), 32'd0);
    tick(2);
    start_dl();
    send_fhdr(32'h40, 16'h0000, 8'h00, 8'h01, -1);
    new_pkt(24'h100000);
    send_chip("CHIP", 32'h20, 16'h0000, 16'h0000, 16'h8000, 16'h0010);
    check("r2_bank_wr", 32'(bus.cart_bank_wr), 32'd1);
    check("r2_raddr",   32'(bus.cart_bank_raddr), 32'h100000);
    send_payload(0, 16);
    stop_dl();
    check("r2_attached", 32'(bus.cart_attached), 32'd1);
    check("r2_error",    32'(bus.crt_error), 32'd0);
    tick(2);
    check("final_wr_seq", 32'(wr_bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
